id_ex_pipe: RTL and testbench
=============================

# id_ex_pipe

- Pipeline register between instruction decode and execute in the pipelined MIPS datapath.
- Latches the main-control outputs, register operands, immediate and PC+4 for each decoded instruction. The control outputs are MemRead, MemWrite, MemToReg, ALUSrc, RegWrite, RegDst, Branch, Jump and ALUOp.
- Detects lw load-use hazards, inserts bubbles and honours flush and downstream hold.
- Counts inserted bubbles for performance debug.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register-index width
- CNT_W, 16, bubble-counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  ctrl_t  decoded control fields: MemRead, MemWrite, MemToReg, ALUSrc, RegWrite, RegDst, Branch, Jump, ALUOp[1:0]
- id_rs, id_rt, id_rd  in  REG_AW  register indices
- id_rd1, id_rd2  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_pc4  in  DATA_W  PC+4
- id_funct  in  6  function field
- flush  in  1  branch/jump taken, kill the ID instruction
- ex_hold  in  1  EX cannot accept, freeze this stage
- stall_if_id  out  1  freeze PC and IF/ID
- ex_valid  out  1  EX holds a real instruction
- ex_ctrl  out  ctrl_t  registered control
- ex_rs, ex_rt  out  REG_AW  registered indices
- ex_wreg  out  REG_AW  destination: RegDst ? rd : rt
- ex_rd1, ex_rd2, ex_imm, ex_pc4  out  DATA_W  registered data
- ex_funct  out  6  registered funct
- bubble_cnt  out  CNT_W  saturating bubble count

## Operation
Load-use hazard:
- load_use = ex_valid & ex_ctrl.MemRead & id_valid & ex_rt≠0 & (ex_rt==id_rs | ex_rt==id_rt).
- Register 0 never causes a hazard.

stall_if_id = (load_use | ex_hold) & ~flush.

Per-edge update, in priority order:
1. rst_n low: all outputs zero.
2. flush: load a bubble.
3. ex_hold: keep every register unchanged; the counter is unchanged.
4. load_use: load a bubble; bubble_cnt += 1.
5. Otherwise: load the ID fields. ex_valid = id_valid. If id_valid = 0, the control fields are forced to 0.

Bubble definition:
- ex_valid = 0 and all ex_ctrl bits = 0.
- The data fields may retain any value; they are don't-care.

ex_wreg is computed from id_ctrl.RegDst at load time and registered.

bubble_cnt saturates at 2^CNT_W−1 and does not wrap. A flush bubble is not counted.

## Timing
- Latency: 1 cycle from ID inputs to ex_* outputs.
- stall_if_id is combinational from the ID inputs and the EX registers, valid in the same cycle.
- The load-use stall lasts exactly 1 cycle. On the next edge the lw has moved on and the bubble is in EX, so load_use deasserts.
- Reset is asynchronous assert and synchronous deassert, handled by the top level. The reset value of every output is 0, including stall_if_id while rst_n is low.
- flush and load_use in the same cycle: flush wins, and stall_if_id = 0.
- flush and ex_hold in the same cycle: flush wins. The killed instruction must not survive a hold.
- Reset mid-stall: all state clears, and no bubble is counted on the reset edge.

## Structure
- Package mips_pkg, shared with the main control decoder and the ALU control:
  - ctrl_t packed struct, in the order listed above
  - CTRL_NOP constant (all zero)
  - opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_J=6'b000010
- Sub-module load_use_detect: purely combinational. Inputs ex_valid, ex_MemRead, ex_rt, id_valid, id_rs, id_rt; output load_use.
- The registers and the counter live in id_ex_pipe.

## Test plan
- Reset: drive rst_n low mid-cycle -> all outputs 0 immediately (asynchronous); with rst_n released and id_valid=1, R-type with rd=3, rt=2 -> next cycle ex_valid=1, ex_wreg=3, ex_ctrl.ALUOp=2'b10.
- Load-use: lw with rt=5, then add with rs=5 -> stall_if_id=1 for exactly one cycle; EX sees lw, bubble, add; bubble_cnt=1.
- No false hazard: lw with rt=0, then add with rs=0 -> no stall; lw with rt=5, then add with rs=6, rt=7 -> no stall.
- Flush priority: flush=1 together with a load-use condition -> bubble loaded, stall_if_id=0, bubble_cnt unchanged.
- Hold: ex_hold=1 for 3 cycles with sw in EX -> ex_* stable and stall_if_id=1 throughout; on release the next instruction loads.
- Saturation: CNT_W=2, 5 load-use events -> bubble_cnt=3, no wrap.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: control bundle
// and the opcodes decoded by main control.
package mips_pkg;

  typedef struct packed {
    logic       MemRead;
    logic       MemWrite;
    logic       MemToReg;
    logic       ALUSrc;
    logic       RegWrite;
    logic       RegDst;
    logic       Branch;
    logic       Jump;
    logic [1:0] ALUOp;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/id_ex_pipe_if.sv
// ID/EX boundary bundle: decode-side fields in,
// execute-side registered fields and stall out.
interface id_ex_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  import mips_pkg::*;

  logic              id_valid;
  ctrl_t             id_ctrl;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_pc4;
  logic [5:0]        id_funct;
  logic              flush;
  logic              ex_hold;

  logic              stall_if_id;
  logic              ex_valid;
  ctrl_t             ex_ctrl;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_wreg;
  logic [DATA_W-1:0] ex_rd1;
  logic [DATA_W-1:0] ex_rd2;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_pc4;
  logic [5:0]        ex_funct;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_ctrl, id_rs, id_rt, id_rd,
    output id_rd1, id_rd2, id_imm, id_pc4, id_funct,
    output flush, ex_hold,
    input  stall_if_id, ex_valid, ex_ctrl,
    input  ex_rs, ex_rt, ex_wreg,
    input  ex_rd1, ex_rd2, ex_imm, ex_pc4,
    input  ex_funct, bubble_cnt
  );

  modport slave (
    input  id_valid, id_ctrl, id_rs, id_rt, id_rd,
    input  id_rd1, id_rd2, id_imm, id_pc4, id_funct,
    input  flush, ex_hold,
    output stall_if_id, ex_valid, ex_ctrl,
    output ex_rs, ex_rt, ex_wreg,
    output ex_rd1, ex_rd2, ex_imm, ex_pc4,
    output ex_funct, bubble_cnt
  );

endinterface

// File: rtl/id_ex_pipe_load_use_detect.sv
// Combinational lw load-use hazard check between
// the load sitting in EX and the instruction in ID.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  output logic              load_use_o
);

  logic rt_hit;

  // $zero is hardwired, so a load into it never blocks
  assign rt_hit = (ex_rt_i != '0) &
                  ((ex_rt_i == id_rs_i) |
                   (ex_rt_i == id_rt_i));

  assign load_use_o = ex_valid_i & ex_mem_read_i &
                      id_valid_i & rt_hit;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble
// insertion, flush, downstream hold, bubble counter.
module id_ex_pipe
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_pipe_if.slave bus
);

  logic              valid_q, valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [REG_AW-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  logic [5:0]        funct_q, funct_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic load_use;
  logic do_fl, do_hd, do_lu;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_lud (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.MemRead),
    .ex_rt_i       (rt_q),
    .id_valid_i    (bus.id_valid),
    .id_rs_i       (bus.id_rs),
    .id_rt_i       (bus.id_rt),
    .load_use_o    (load_use)
  );

  // one-hot view of the update priority
  assign do_fl = bus.flush;
  assign do_hd = ~bus.flush & bus.ex_hold;
  assign do_lu = ~bus.flush & ~bus.ex_hold & load_use;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    wreg_d  = wreg_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    pc4_d   = pc4_q;
    funct_d = funct_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      do_fl: begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_NOP;
      end
      do_hd: ;
      do_lu: begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_NOP;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
      default: begin
        valid_d = bus.id_valid;
        ctrl_d  = bus.id_valid ? bus.id_ctrl : CTRL_NOP;
        rs_d    = bus.id_rs;
        rt_d    = bus.id_rt;
        wreg_d  = bus.id_ctrl.RegDst ? bus.id_rd
                                     : bus.id_rt;
        rd1_d   = bus.id_rd1;
        rd2_d   = bus.id_rd2;
        imm_d   = bus.id_imm;
        pc4_d   = bus.id_pc4;
        funct_d = bus.id_funct;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
      rs_q    <= '0;
      rt_q    <= '0;
      wreg_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
      funct_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      wreg_q  <= wreg_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc4_q   <= pc4_d;
      funct_q <= funct_d;
      cnt_q   <= cnt_d;
    end
  end

  // stall must read 0 while reset is asserted
  assign bus.stall_if_id = rst_n & ~bus.flush &
                           (load_use | bus.ex_hold);

  assign bus.ex_valid   = valid_q;
  assign bus.ex_ctrl    = ctrl_q;
  assign bus.ex_rs      = rs_q;
  assign bus.ex_rt      = rt_q;
  assign bus.ex_wreg    = wreg_q;
  assign bus.ex_rd1     = rd1_q;
  assign bus.ex_rd2     = rd2_q;
  assign bus.ex_imm     = imm_q;
  assign bus.ex_pc4     = pc4_q;
  assign bus.ex_funct   = funct_q;
  assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed table, corner
// sequences, saturation and random vs. a model.
module tb_id_ex_pipe;
  import mips_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  localparam ctrl_t C_R  = 10'b0000110010;
  localparam ctrl_t C_LW = 10'b1011100000;
  localparam ctrl_t C_SW = 10'b0101000000;
  localparam ctrl_t C_0  = 10'b0000000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_pipe_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) bus ();
  id_ex_pipe_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(2)) bus2 ();

  id_ex_pipe #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  id_ex_pipe #(.DATA_W(DW), .REG_AW(AW), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    logic       v;
    ctrl_t      c;
    logic [4:0] rs, rt, rd;
    logic       fl, hd;
    logic       e_st, e_v;
    ctrl_t      e_c;
    logic [4:0] e_w;
    int         e_cnt;
    int         src;
  } vec_t;

  function automatic vec_t mkv(
    logic v, ctrl_t c, int rs, int rt, int rd,
    logic fl, logic hd, logic est, logic ev,
    ctrl_t ec, int ew, int ecnt, int src);
    vec_t t;
    t.v = v; t.c = c;
    t.rs = 5'(rs); t.rt = 5'(rt); t.rd = 5'(rd);
    t.fl = fl; t.hd = hd;
    t.e_st = est; t.e_v = ev; t.e_c = ec;
    t.e_w = 5'(ew); t.e_cnt = ecnt; t.src = src;
    return t;
  endfunction

  task automatic set_id(logic v, ctrl_t c, int rs,
                        int rt, int rd, logic fl,
                        logic hd, int tag);
    bus.id_valid = v;
    bus.id_ctrl  = c;
    bus.id_rs    = 5'(rs);
    bus.id_rt    = 5'(rt);
    bus.id_rd    = 5'(rd);
    bus.id_rd1   = 32'h100 + 32'(tag);
    bus.id_rd2   = 32'h200 + 32'(tag);
    bus.id_imm   = 32'h300 + 32'(tag);
    bus.id_pc4   = 32'h400 + 32'(tag);
    bus.id_funct = 6'(tag);
    bus.flush    = fl;
    bus.ex_hold  = hd;
  endtask

  task automatic set2(logic v, ctrl_t c, int rs,
                      int rt, int rd);
    bus2.id_valid = v;
    bus2.id_ctrl  = c;
    bus2.id_rs    = 5'(rs);
    bus2.id_rt    = 5'(rt);
    bus2.id_rd    = 5'(rd);
    bus2.id_rd1   = '0;
    bus2.id_rd2   = '0;
    bus2.id_imm   = '0;
    bus2.id_pc4   = '0;
    bus2.id_funct = '0;
    bus2.flush    = 1'b0;
    bus2.ex_hold  = 1'b0;
  endtask

  // behavioural model: contents of the EX slot
  typedef struct {
    logic        v;
    ctrl_t       c;
    logic [4:0]  rs, rt, w;
    logic [31:0] rd1, rd2, imm, pc4;
    logic [5:0]  fn;
  } slot_t;

  slot_t m;
  int    m_cnt;

  vec_t tbl[$];

  initial begin
    set_id(1'b0, C_0, 0, 0, 0, 1'b0, 1'b0, 0);
    set2(1'b0, C_0, 0, 0, 0);

    // ---- asynchronous reset ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_id(1'b1, C_R, 1, 2, 3, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    chk("pre_rst valid", bus.ex_valid, 1);
    chk("pre_rst wreg", bus.ex_wreg, 3);
    chk("pre_rst aluop", bus.ex_ctrl.ALUOp, 2'b10);
    #2;
    bus.ex_hold = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst valid", bus.ex_valid, 0);
    chk("rst ctrl", bus.ex_ctrl, C_0);
    chk("rst wreg", bus.ex_wreg, 0);
    chk("rst rd1", bus.ex_rd1, 0);
    chk("rst cnt", bus.bubble_cnt, 0);
    chk("rst stall", bus.stall_if_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_id(1'b0, C_0, 0, 0, 0, 1'b0, 1'b0, 0);
    @(posedge clk); #1;

    // ---- directed table ----
    tbl.push_back(mkv(1, C_R, 1, 2, 3, 0, 0,
                      0, 1, C_R, 3, 0, 0));
    tbl.push_back(mkv(1, C_LW, 1, 5, 0, 0, 0,
                      0, 1, C_LW, 5, 0, 1));
    tbl.push_back(mkv(1, C_R, 5, 6, 7, 0, 0,
                      1, 0, C_0, 0, 1, 2));
    tbl.push_back(mkv(1, C_R, 5, 6, 7, 0, 0,
                      0, 1, C_R, 7, 1, 3));
    tbl.push_back(mkv(1, C_LW, 2, 0, 0, 0, 0,
                      0, 1, C_LW, 0, 1, 4));
    tbl.push_back(mkv(1, C_R, 0, 0, 4, 0, 0,
                      0, 1, C_R, 4, 1, 5));
    tbl.push_back(mkv(1, C_LW, 2, 5, 0, 0, 0,
                      0, 1, C_LW, 5, 1, 6));
    tbl.push_back(mkv(1, C_R, 6, 7, 8, 0, 0,
                      0, 1, C_R, 8, 1, 7));
    tbl.push_back(mkv(1, C_LW, 2, 5, 0, 0, 0,
                      0, 1, C_LW, 5, 1, 8));
    tbl.push_back(mkv(1, C_R, 5, 1, 9, 1, 0,
                      0, 0, C_0, 0, 1, 9));
    tbl.push_back(mkv(1, C_SW, 1, 2, 0, 0, 0,
                      0, 1, C_SW, 2, 1, 10));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mkv(1, C_R, 3, 4, 9, 0, 1,
                        1, 1, C_SW, 2, 1, 10));
    tbl.push_back(mkv(1, C_R, 3, 4, 9, 0, 0,
                      0, 1, C_R, 9, 1, 14));
    tbl.push_back(mkv(0, C_R, 5, 6, 7, 0, 0,
                      0, 0, C_0, 0, 1, 15));
    tbl.push_back(mkv(1, C_LW, 1, 5, 0, 0, 0,
                      0, 1, C_LW, 5, 1, 16));
    tbl.push_back(mkv(1, C_R, 5, 6, 7, 1, 1,
                      0, 0, C_0, 0, 1, 17));

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t t;
      t = tbl[i];
      set_id(t.v, t.c, t.rs, t.rt, t.rd,
             t.fl, t.hd, i);
      @(negedge clk);
      chk($sformatf("v%0d stall", i),
          bus.stall_if_id, t.e_st);
      @(posedge clk); #1;
      chk($sformatf("v%0d valid", i),
          bus.ex_valid, t.e_v);
      chk($sformatf("v%0d ctrl", i),
          bus.ex_ctrl, t.e_c);
      chk($sformatf("v%0d cnt", i),
          bus.bubble_cnt, t.e_cnt);
      if (t.e_v) begin
        chk($sformatf("v%0d wreg", i),
            bus.ex_wreg, t.e_w);
        chk($sformatf("v%0d rd1", i),
            bus.ex_rd1, 32'h100 + 32'(t.src));
      end
    end

    // ---- reset in the middle of a load-use stall ----
    set_id(1'b1, C_LW, 1, 5, 0, 1'b0, 1'b0, 40);
    @(posedge clk); #1;
    set_id(1'b1, C_R, 5, 6, 7, 1'b0, 1'b0, 41);
    @(negedge clk);
    chk("mid stall", bus.stall_if_id, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid rst cnt", bus.bubble_cnt, 0);
    chk("mid rst valid", bus.ex_valid, 0);
    chk("mid rst stall", bus.stall_if_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_id(1'b0, C_0, 0, 0, 0, 1'b0, 1'b0, 0);
    @(posedge clk); #1;

    // ---- saturation of a 2-bit counter ----
    for (int k = 1; k <= 5; k++) begin
      set2(1'b1, C_LW, 1, 5, 0);
      @(posedge clk); #1;
      set2(1'b1, C_R, 5, 6, 7);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk($sformatf("sat%0d cnt", k),
          bus2.bubble_cnt, (k > 3) ? 3 : k);
    end
    set2(1'b0, C_0, 0, 0, 0);

    // ---- random vs. model ----
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m = '{default: '0};
    m_cnt = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 400; i++) begin
      logic        rv, fl, hd, lu, est;
      ctrl_t       c;
      logic [4:0]  rs, rt, rd;
      logic [31:0] d1, d2, im, pc;
      logic [5:0]  fn;
      rv = ($urandom_range(0, 7) != 0);
      c  = ctrl_t'($urandom);
      if ($urandom_range(0, 1) == 1) c.MemRead = 1'b1;
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 31));
      d1 = $urandom; d2 = $urandom;
      im = $urandom; pc = $urandom;
      fn = 6'($urandom);
      fl = ($urandom_range(0, 9) == 0);
      hd = ($urandom_range(0, 7) == 0);
      bus.id_valid = rv; bus.id_ctrl = c;
      bus.id_rs = rs; bus.id_rt = rt;
      bus.id_rd = rd;
      bus.id_rd1 = d1; bus.id_rd2 = d2;
      bus.id_imm = im; bus.id_pc4 = pc;
      bus.id_funct = fn;
      bus.flush = fl; bus.ex_hold = hd;

      lu = m.v && m.c.MemRead && rv && m.rt != 0
           && (m.rt == rs || m.rt == rt);
      est = (lu || hd) && !fl;
      @(negedge clk);
      chk($sformatf("r%0d stall", i),
          bus.stall_if_id, est);
      @(posedge clk);
      if (fl || (!hd && lu)) begin
        m.v = 1'b0;
        m.c = C_0;
        if (!fl && m_cnt < (1 << CW) - 1) m_cnt++;
      end else if (!hd) begin
        m.v = rv;
        m.c = rv ? c : C_0;
        m.rs = rs; m.rt = rt;
        m.w = c.RegDst ? rd : rt;
        m.rd1 = d1; m.rd2 = d2;
        m.imm = im; m.pc4 = pc; m.fn = fn;
      end
      #1;
      chk($sformatf("r%0d valid", i), bus.ex_valid, m.v);
      chk($sformatf("r%0d ctrl", i), bus.ex_ctrl, m.c);
      chk($sformatf("r%0d cnt", i),
          bus.bubble_cnt, m_cnt);
      if (m.v) begin
        chk($sformatf("r%0d rs", i), bus.ex_rs, m.rs);
        chk($sformatf("r%0d rt", i), bus.ex_rt, m.rt);
        chk($sformatf("r%0d wreg", i),
            bus.ex_wreg, m.w);
        chk($sformatf("r%0d rd1", i), bus.ex_rd1, m.rd1);
        chk($sformatf("r%0d rd2", i), bus.ex_rd2, m.rd2);
        chk($sformatf("r%0d imm", i), bus.ex_imm, m.imm);
        chk($sformatf("r%0d pc4", i), bus.ex_pc4, m.pc4);
        chk($sformatf("r%0d fn", i),
            bus.ex_funct, m.fn);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
